// File: rtl/pair_sequencer.sv
// -----------------------------------------------------------------------------
// pair_sequencer
//
// Sequences the particle filter datapath. Accepts one reference particle plus
// its bank of NSLOT neighbor slots. Null slots are skipped, and the sequencer
// issues one (reference, neighbor) pair per cycle under valid/ready
// backpressure. A sticky `done` is raised once the read controller has
// finished, every pair has been issued and the force pipeline is idle.
//
// Ports
//   clk, reset            : single clock; asynchronous active-low reset
//   in_valid/in_ready     : group handshake (in_ready depends only on state)
//   in_reference          : reference particle word
//   in_neighbors          : NSLOT neighbor words, slot i at [i*W +: W]
//   pair_valid/pair_ready : pair handshake toward the filter / pair queue
//   pair_reference        : latched reference word
//   pair_neighbor         : neighbor word for the current pair
//   pair_index            : slot index of the current neighbor
//   read_controller_done  : no further groups will be offered
//   pipeline_idle         : filter, pair queue and force pipeline are empty
//   pairs_issued          : count of accepted pairs (wraps at 16 bits)
//   done                  : sticky completion flag
// -----------------------------------------------------------------------------
module pair_sequencer #(
  parameter int NSLOT    = 14,
  parameter int W        = 114,
  parameter int NULL_BIT = 96,
  parameter int IDXW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_reference,
  input  logic [W*NSLOT-1:0]   in_neighbors,
  output logic                 pair_valid,
  input  logic                 pair_ready,
  output logic [W-1:0]         pair_reference,
  output logic [W-1:0]         pair_neighbor,
  output logic [IDXW-1:0]      pair_index,
  input  logic                 read_controller_done,
  input  logic                 pipeline_idle,
  output logic [15:0]          pairs_issued,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

  state_t            state, state_nx;
  logic              alive;          // low during reset and until the first edge after it
  logic [NSLOT-1:0]  mask, mask_nx;  // slots still waiting to be issued
  logic [NSLOT-1:0]  in_live;        // non-null slots of the offered group
  logic [NSLOT-1:0]  sel_src;
  logic [IDXW-1:0]   sel_idx;
  logic [W-1:0]      sel_word;
  logic              accept, issue, load;
  logic [W-1:0]      nbr_q [NSLOT];

  // Lowest set bit wins, so slots are issued in ascending index order.
  function automatic logic [IDXW-1:0] lowest_set(input logic [NSLOT-1:0] m);
    lowest_set = '0;
    for (int i = NSLOT - 1; i >= 0; i--)
      if (m[i]) lowest_set = IDXW'(i);
  endfunction

  assign in_ready = alive & (state == IDLE);
  assign accept   = in_valid & in_ready;
  // pair_valid is high throughout SCAN, so the handshake only needs pair_ready.
  assign issue    = (state == SCAN) & pair_ready;

  // NOTE: every variable driven in always_comb gets a default at the top of the
  // block. A path that leaves a variable unassigned would infer a latch.
  always_comb begin
    in_live = '0;
    for (int i = 0; i < NSLOT; i++)
      in_live[i] = ~in_neighbors[i*W + NULL_BIT];
  end

  always_comb begin
    state_nx = state;
    mask_nx  = mask;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        // A group on offer takes priority over finishing.
        if (accept) begin
          mask_nx = in_live;
          if (|in_live) begin
            state_nx = SCAN;
            load     = 1'b1;
          end
        end else if (read_controller_done) begin
          state_nx = FINISH;
        end
      end
      SCAN: begin
        if (pair_ready) begin
          mask_nx = mask & ~({{(NSLOT-1){1'b0}}, 1'b1} << pair_index);
          if (|mask_nx) load     = 1'b1;
          else          state_nx = IDLE;
        end
      end
      FINISH:  ;
      default: state_nx = IDLE;
    endcase
  end

  // Registered pair data comes from the new mask. On accept it also comes from
  // the live input bus, because the buffer is written on the same edge.
  always_comb begin
    sel_src  = (state == IDLE) ? in_live : mask_nx;
    sel_idx  = lowest_set(sel_src);
    sel_word = '0;
    for (int i = 0; i < NSLOT; i++)
      if (sel_idx == IDXW'(i))
        sel_word = (state == IDLE) ? in_neighbors[i*W +: W] : nbr_q[i];
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop then
  // samples pre-edge values, and there is no ordering race between processes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      alive          <= 1'b0;
      mask           <= '0;
      pair_valid     <= 1'b0;
      pair_reference <= '0;
      pair_neighbor  <= '0;
      pair_index     <= '0;
      pairs_issued   <= '0;
      done           <= 1'b0;
    end else begin
      state      <= state_nx;
      alive      <= 1'b1;
      mask       <= mask_nx;
      pair_valid <= (state_nx == SCAN);
      if (accept) pair_reference <= in_reference;
      if (load) begin
        pair_index    <= sel_idx;
        pair_neighbor <= sel_word;
      end
      if (issue) pairs_issued <= pairs_issued + 16'd1;
      if ((state == FINISH) && pipeline_idle) done <= 1'b1;
    end
  end

  // NOTE: the neighbor buffer is data only and is not reset. The mask decides
  // which entries are meaningful, and leaving reset off keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (accept)
      for (int i = 0; i < NSLOT; i++) nbr_q[i] <= in_neighbors[i*W +: W];
  end

endmodule

// File: tb/tb_pair_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pair_sequencer
//
// Self-checking bench for pair_sequencer. It has three parts:
//   - table-driven group vectors
//   - hand-written sequences for backpressure, reset and completion
//   - a randomized run checked against a queue-based reference model
// -----------------------------------------------------------------------------
module tb_pair_sequencer;
  localparam int NSLOT    = 14;
  localparam int W        = 114;
  localparam int NULL_BIT = 96;
  localparam int IDXW     = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [W-1:0]        in_reference = '0;
  logic [W*NSLOT-1:0]  in_neighbors = '0;
  logic                pair_valid;
  logic                pair_ready = 1'b0;
  logic [W-1:0]        pair_reference;
  logic [W-1:0]        pair_neighbor;
  logic [IDXW-1:0]     pair_index;
  logic                read_controller_done = 1'b0;
  logic                pipeline_idle = 1'b0;
  logic [15:0]         pairs_issued;
  logic                done;

  pair_sequencer #(.NSLOT(NSLOT), .W(W), .NULL_BIT(NULL_BIT), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reference(in_reference), .in_neighbors(in_neighbors),
    .pair_valid(pair_valid), .pair_ready(pair_ready),
    .pair_reference(pair_reference), .pair_neighbor(pair_neighbor),
    .pair_index(pair_index),
    .read_controller_done(read_controller_done), .pipeline_idle(pipeline_idle),
    .pairs_issued(pairs_issued), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0]     words [NSLOT];  // words of the most recently built group
  logic [NSLOT-1:0] cur_live;
  logic [15:0]      exp_issued = 16'd0;

  task automatic make_group(input logic [NSLOT-1:0] live);
    for (int i = 0; i < NSLOT; i++) begin
      words[i] = W'({$urandom, $urandom, $urandom, $urandom});
      words[i][NULL_BIT] = ~live[i];
      in_neighbors[i*W +: W] = words[i];
    end
    in_reference = W'({$urandom, $urandom, $urandom, $urandom});
    cur_live = live;
  endtask

  typedef struct {
    logic [NSLOT-1:0] live;
    int               npairs;
    int               first;
    int               last;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int               cnt, prev, first_i, last_i, cyc;
    logic [W-1:0]     hold_nbr, hold_ref, saved [NSLOT];
    logic [IDXW-1:0]  hold_idx;
    int               q [$];
    logic [W-1:0]     mwords [NSLOT];
    logic [W-1:0]     mref;

    vecs[0] = '{14'h3FFF, 14, 0, 13};   // full group
    vecs[1] = '{14'h0808, 2, 3, 11};    // sparse: slots 3 and 11
    vecs[2] = '{14'h0000, 0, 0, 0};     // all null
    vecs[3] = '{14'h2000, 1, 13, 13};   // only the top slot
    vecs[4] = '{14'h0001, 1, 0, 0};     // only slot 0
    vecs[5] = '{14'h1555, 7, 0, 12};    // even slots

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_pair_valid", pair_valid, 0);
    check("rst_pair_ref", pair_reference, 0);
    check("rst_pair_nbr", pair_neighbor, 0);
    check("rst_pair_index", pair_index, 0);
    check("rst_issued", pairs_issued, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);

    // ---------------- table-driven groups ----------------
    pair_ready = 1'b1;
    foreach (vecs[v]) begin
      make_group(vecs[v].live);
      check($sformatf("tbl%0d_ready", v), in_ready, 1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      cnt = 0; first_i = -1; last_i = -1; cyc = 0; prev = -1;
      while (pair_valid && cyc < 40) begin
        check($sformatf("tbl%0d_nbr", v), pair_neighbor, words[pair_index]);
        check($sformatf("tbl%0d_ref", v), pair_reference, in_reference);
        check($sformatf("tbl%0d_order", v), int'(pair_index) > prev, 1);
        check($sformatf("tbl%0d_in_ready_busy", v), in_ready, 0);
        prev = int'(pair_index);
        if (cnt == 0) first_i = int'(pair_index);
        last_i = int'(pair_index);
        cnt++;
        step();
        cyc++;
      end
      exp_issued += 16'(vecs[v].npairs);
      check($sformatf("tbl%0d_count", v), cnt, vecs[v].npairs);
      if (vecs[v].npairs > 0) begin
        check($sformatf("tbl%0d_first", v), first_i, vecs[v].first);
        check($sformatf("tbl%0d_last", v), last_i, vecs[v].last);
      end
      check($sformatf("tbl%0d_ready_after", v), in_ready, 1);
      check($sformatf("tbl%0d_issued", v), pairs_issued, exp_issued);
    end

    // ---------------- backpressure on slot 0 ----------------
    make_group(14'h0025);  // slots 0, 2, 5
    for (int i = 0; i < NSLOT; i++) saved[i] = words[i];
    hold_ref = in_reference;
    in_valid = 1'b1;
    pair_ready = 1'b0;
    step();
    hold_idx = pair_index;
    hold_nbr = pair_neighbor;
    check("bp_first_idx", pair_index, 0);
    check("bp_first_nbr", pair_neighbor, saved[0]);
    for (int c = 0; c < 3; c++) begin
      // Scramble the inputs while stalled; the latched group must not change.
      in_neighbors = {NSLOT{W'({$urandom, $urandom, $urandom, $urandom})}};
      in_reference = W'({$urandom, $urandom, $urandom, $urandom});
      step();
      check("bp_hold_valid", pair_valid, 1);
      check("bp_hold_idx", pair_index, hold_idx);
      check("bp_hold_nbr", pair_neighbor, hold_nbr);
      check("bp_hold_ref", pair_reference, hold_ref);
      check("bp_hold_ready", in_ready, 0);
      check("bp_hold_issued", pairs_issued, exp_issued);
    end
    in_valid = 1'b0;
    pair_ready = 1'b1;
    step();
    check("bp_adv_idx", pair_index, 2);
    check("bp_adv_nbr", pair_neighbor, saved[2]);
    step();
    check("bp_adv2_idx", pair_index, 5);
    check("bp_adv2_nbr", pair_neighbor, saved[5]);
    step();
    exp_issued += 16'd3;
    check("bp_end_valid", pair_valid, 0);
    check("bp_end_issued", pairs_issued, exp_issued);

    // ---------------- randomized run vs queue model ----------------
    q.delete();
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      pair_ready = ($urandom_range(0, 3) != 0);
      make_group(($urandom_range(0, 5) == 0) ? '0 : NSLOT'($urandom));
      check("rnd_in_ready", in_ready, q.size() == 0);
      check("rnd_pair_valid", pair_valid, q.size() != 0);
      check("rnd_issued", pairs_issued, exp_issued);
      if (q.size() != 0) begin
        check("rnd_idx", pair_index, q[0]);
        check("rnd_nbr", pair_neighbor, mwords[q[0]]);
        check("rnd_ref", pair_reference, mref);
      end
      if (q.size() == 0 && in_valid) begin
        for (int i = 0; i < NSLOT; i++) begin
          mwords[i] = words[i];
          if (cur_live[i]) q.push_back(i);
        end
        mref = in_reference;
      end else if (q.size() != 0 && pair_ready) begin
        void'(q.pop_front());
        exp_issued++;
      end
      step();
    end
    in_valid = 1'b0;
    pair_ready = 1'b1;
    cyc = 0;
    while (pair_valid && cyc < 20) begin
      step();
      cyc++;
    end
    check("rnd_drain", pair_valid, 0);

    // ---------------- reset mid-SCAN with 5 pending ----------------
    make_group(14'h00FF);  // 8 valid slots
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();  // 3 issued, 5 pending
    check("mid_rst_pending_valid", pair_valid, 1);
    check("mid_rst_pending_idx", pair_index, 3);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", pair_valid, 0);
    check("mid_rst_issued", pairs_issued, 0);
    check("mid_rst_in_ready", in_ready, 0);
    step();
    reset = 1'b1;
    exp_issued = 16'd0;
    step();
    check("mid_rst_ready_after", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      check("mid_rst_no_stray", pair_valid, 0);
      step();
    end
    check("mid_rst_issued_after", pairs_issued, 0);

    // ---------------- completion ----------------
    make_group(14'h0F00);  // slots 8..11
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    read_controller_done = 1'b1;
    pipeline_idle = 1'b0;
    cnt = 0; cyc = 0;
    while (pair_valid && cyc < 20) begin
      check("fin_no_done_scan", done, 0);
      cnt++;
      step();
      cyc++;
    end
    check("fin_all_pairs", cnt, 4);
    check("fin_issued", pairs_issued, 4);
    check("fin_idle_ready", in_ready, 1);
    step();
    in_valid = 1'b1;  // offered in FINISH: must be refused
    for (int c = 0; c < 3; c++) begin
      check("fin_in_ready", in_ready, 0);
      check("fin_done_wait", done, 0);
      check("fin_no_pair", pair_valid, 0);
      step();
    end
    pipeline_idle = 1'b1;
    check("fin_done_pre", done, 0);
    step();
    check("fin_done_rise", done, 1);
    pipeline_idle = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("fin_done_sticky", done, 1);
    end
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
